// File: rtl/cpu3_pkg.sv
// cpu3_pkg: types and constants shared by the cpu3 fetch and decode stages.
//   fetch_state_e : fetch FSM encoding (RUN, HALTED, FAULT)
//   HALT_INSTR    : encoding recognised as halt (opcode 6'h3F)
//   NOP_INSTR     : encoding placed into IF/ID for a bubble
//   ifid_t        : IF/ID pipeline register contents
package cpu3_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter register for the fetch stage.
//   clk, rst_ : rising-edge clock, asynchronous active-low reset (pc -> RESET_PC)
//   load      : load load_pc (highest priority)
//   load_pc   : byte address to load
//   inc       : advance pc by 4 (32-bit wrap)
//   pc        : current program counter
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of cpu3. Owns the PC, drives the word
// address to i_memory (combinational read) and registers instruction and
// PC+4 into IF/ID. Handles stall, redirect with flush, halt detection and
// sticky fetch faults.
//   clk, rst_        : rising-edge clock, asynchronous active-low reset
//   imem_addr        : word address to i_memory (pc[2 +: AW])
//   imem_rdata       : instruction word for imem_addr
//   stall            : hold pc and IF/ID
//   redirect_valid   : taken branch/jump, load redirect_pc and flush IF/ID
//   redirect_pc      : redirect byte target
//   pc               : current fetch PC
//   ifid_instr/pc4/valid : IF/ID register
//   halt_fetched     : halt instruction entered IF/ID, fetching stopped
//   exception        : sticky fetch fault (misaligned or out-of-range PC)
module fetch_unit
  import cpu3_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_INSTR = cpu3_pkg::HALT_INSTR,
  parameter logic [31:0] NOP_INSTR  = cpu3_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst_,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   pc,
  output logic [31:0]                   ifid_instr,
  output logic [31:0]                   ifid_pc4,
  output logic                          ifid_valid,
  output logic                          halt_fetched,
  output logic                          exception
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  // One bit wider than the PC so a limit of 2^32 would still compare correctly.
  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_DEPTH);
  localparam ifid_t       BUBBLE   = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  fetch_state_e state_d, state_q;
  ifid_t        ifid_d, ifid_q;
  logic         halt_d, halt_q;
  logic         exc_d, exc_q;

  logic         pc_load;
  logic         pc_inc;
  logic         pc_fault;
  logic [31:0]  pc_plus4;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_    (rst_),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign imem_addr = pc[2 +: AW];
  assign pc_plus4  = pc + 32'd4;
  assign pc_fault  = (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);

  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    halt_d  = halt_q;
    exc_d   = exc_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          ifid_d  = BUBBLE;
          halt_d  = 1'b0;
        end else if (pc_fault) begin
          ifid_d  = BUBBLE;
          exc_d   = 1'b1;
          state_d = FAULT;
        end else if (!stall) begin
          ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
          // A halt word is latched but the PC is frozen on it so a redirect
          // can still squash a speculatively fetched halt.
          if (imem_rdata == HALT_INSTR) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          ifid_d  = BUBBLE;
          halt_d  = 1'b0;
          state_d = RUN;
        end else if (!stall) begin
          ifid_d = BUBBLE;
        end
      end
      FAULT: begin
        ifid_d = BUBBLE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= RUN;
      ifid_q  <= BUBBLE;
      halt_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      halt_q  <= halt_d;
      exc_q   <= exc_d;
    end
  end

  assign ifid_instr   = ifid_q.instr;
  assign ifid_pc4     = ifid_q.pc4;
  assign ifid_valid   = ifid_q.valid;
  assign halt_fetched = halt_q;
  assign exception    = exc_q;

endmodule
